multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 242 ++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle datapath controller: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer with a
// memory-wait watchdog, sticky illegal/bus_error flags and a retired-instruction counter.
module multicycle_control #(
  parameter int unsigned OPW         = 6,
  parameter int unsigned FW          = 6,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNTW        = 16
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [OPW-1:0]  opcode,
  input  logic [FW-1:0]   funct,
  input  logic            mem_ready,
  input  logic            Stall,
  output logic [1:0]      RegDst,
  output logic            ALUSrc,
  output logic [1:0]      MemtoReg,
  output logic            MemWrite,
  output logic            MemRead,
  output logic [3:0]      ALUOp,
  output logic            RegWrite,
  output logic            Branch,
  output logic [1:0]      Jump,
  output logic            halt,
  output logic            PCWrite,
  output logic            IRWrite,
  output logic [2:0]      state,
  output logic            illegal,
  output logic            bus_error,
  output logic [CNTW-1:0] retired
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    ClsIll, ClsR, ClsJs, ClsLw, ClsSw, ClsAddi, ClsAndi, ClsOri, ClsJ, ClsJal, ClsBr, ClsHalt
  } cls_e;

  state_e          state_q, state_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [FW-1:0]   fn_q, fn_d;
  logic [7:0]      wait_q, wait_d;
  logic            illegal_q, illegal_d;
  logic            bus_error_q, bus_error_d;
  logic [CNTW-1:0] retired_q, retired_d;
  cls_e            cls_live, cls_lat;

  // Any opcode bit above the low six makes the instruction illegal.
  function automatic cls_e classify(input logic [OPW-1:0] op, input logic [FW-1:0] fn);
    cls_e c;
    case (op[5:0])
      6'b000000: c = (fn[5:0] == 6'b001000) ? ClsJs : ClsR;
      6'b100011: c = ClsLw;
      6'b101011: c = ClsSw;
      6'b001000: c = ClsAddi;
      6'b001100: c = ClsAndi;
      6'b001101: c = ClsOri;
      6'b000010: c = ClsJ;
      6'b000011: c = ClsJal;
      6'b000100, 6'b000101, 6'b000110, 6'b000111, 6'b001001, 6'b001010: c = ClsBr;
      6'b101101: c = ClsHalt;
      default:   c = ClsIll;
    endcase
    if ((op >> 6) != '0) c = ClsIll;
    return c;
  endfunction

  // DECODE steers from the live IR; later states only ever see the latched copy.
  assign cls_live = classify(opcode, funct);
  assign cls_lat  = classify(op_q, fn_q);

  // State register and all sticky/counting state.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= StFetch;
      op_q        <= '0;
      fn_q        <= '0;
      wait_q      <= '0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      fn_q        <= fn_d;
      wait_q      <= wait_d;
      illegal_q   <= illegal_d;
      bus_error_q <= bus_error_d;
      retired_q   <= retired_d;
    end
  end

  // Next-state, watchdog and counter update; Stall freezes everything.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    fn_d        = fn_q;
    wait_d      = wait_q;
    illegal_d   = illegal_q;
    bus_error_d = bus_error_q;
    retired_d   = retired_q;
    if (!Stall) begin
      wait_d = '0;
      case (state_q)
        StFetch: state_d = StDecode;
        StDecode: begin
          op_d = opcode;
          fn_d = funct;
          case (cls_live)
            ClsR, ClsAddi, ClsAndi, ClsOri, ClsLw, ClsSw, ClsBr: state_d = StExec;
            ClsJ:          state_d = StFetch;
            ClsJal, ClsJs: state_d = StMem;
            ClsHalt:       state_d = StHalt;
            default: begin
              illegal_d = 1'b1;
              state_d   = StFetch;
            end
          endcase
        end
        StExec: begin
          case (cls_lat)
            ClsLw, ClsSw: state_d = StMem;
            ClsBr:        state_d = StFetch;
            default:      state_d = StWb;
          endcase
        end
        StMem: begin
          // A completion arriving on the timeout cycle still counts as success.
          if (mem_ready) begin
            state_d = (cls_lat == ClsSw) ? StFetch : StWb;
          end else if (wait_q == 8'(MEM_TIMEOUT - 1)) begin
            state_d     = StHalt;
            bus_error_d = 1'b1;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end
        StWb:    state_d = StFetch;
        StHalt:  state_d = StHalt;
        default: state_d = StFetch;
      endcase
      if (state_d == StFetch && state_q inside {StDecode, StExec, StMem, StWb} &&
          retired_q != '1) begin
        retired_d = retired_q + 1'b1;
      end
    end
  end

  // Per-state control strobes; Reset and Stall force them all low.
  always_comb begin
    RegDst   = 2'b00;
    ALUSrc   = 1'b0;
    MemtoReg = 2'b00;
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    ALUOp    = 4'b0000;
    RegWrite = 1'b0;
    Branch   = 1'b0;
    Jump     = 2'b00;
    halt     = 1'b0;
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    if (!Reset && !Stall) begin
      case (state_q)
        StFetch: begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
        end
        StDecode: begin
          if (cls_live == ClsJ) begin
            Jump    = 2'b01;
            PCWrite = 1'b1;
          end
        end
        StExec: begin
          ALUSrc = cls_lat inside {ClsLw, ClsSw, ClsAddi, ClsAndi, ClsOri};
          case (cls_lat)
            ClsR:    ALUOp = 4'b0010;
            ClsAndi: ALUOp = 4'b0001;
            ClsOri:  ALUOp = 4'b0011;
            ClsBr: begin
              Branch = 1'b1;
              case (op_q[5:0])
                6'b000100: ALUOp = 4'b0100;
                6'b000101: ALUOp = 4'b0101;
                6'b000110: ALUOp = 4'b0110;
                6'b000111: ALUOp = 4'b0111;
                6'b001001: ALUOp = 4'b1000;
                default:   ALUOp = 4'b1001;
              endcase
            end
            default: ALUOp = 4'b0000;
          endcase
        end
        StMem: begin
          case (cls_lat)
            ClsLw, ClsJs: MemRead = 1'b1;
            ClsSw:        MemWrite = 1'b1;
            ClsJal: begin
              MemWrite = 1'b1;
              Jump     = 2'b01;
              PCWrite  = mem_ready;
            end
            default: ;
          endcase
        end
        StWb: begin
          RegWrite = 1'b1;
          case (cls_lat)
            ClsR:  RegDst = 2'b01;
            ClsLw: MemtoReg = 2'b01;
            ClsJal: begin
              MemtoReg = 2'b10;
              RegDst   = 2'b10;
            end
            ClsJs: begin
              MemtoReg = 2'b11;
              Jump     = 2'b10;
              PCWrite  = 1'b1;
            end
            default: ;
          endcase
        end
        StHalt:  halt = 1'b1;
        default: ;
      endcase
    end
  end

  assign state     = state_q;
  assign illegal   = illegal_q;
  assign bus_error = bus_error_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed scenarios plus randomized instruction streams
// checked against an instruction-level reference model.
module tb_multicycle_control;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [5:0]  opcode, funct;
  logic        mem_ready, Stall;
  logic [1:0]  RegDst, MemtoReg, Jump;
  logic        ALUSrc, MemWrite, MemRead, RegWrite, Branch, halt, PCWrite, IRWrite;
  logic [3:0]  ALUOp;
  logic [2:0]  state;
  logic        illegal, bus_error;
  logic [15:0] retired;
  logic [17:0] ctl;

  int n_checks = 0;
  int n_pass   = 0;

  multicycle_control dut (
    .Clock(Clock), .Reset(Reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .Stall(Stall), .RegDst(RegDst), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .MemWrite(MemWrite),
    .MemRead(MemRead), .ALUOp(ALUOp), .RegWrite(RegWrite), .Branch(Branch), .Jump(Jump),
    .halt(halt), .PCWrite(PCWrite), .IRWrite(IRWrite), .state(state), .illegal(illegal),
    .bus_error(bus_error), .retired(retired)
  );

  always #5 Clock = ~Clock;

  assign ctl = {RegDst, ALUSrc, MemtoReg, MemWrite, MemRead, ALUOp, RegWrite, Branch, Jump,
                halt, PCWrite, IRWrite};

  localparam int K_ILL = 0, K_R = 1, K_JS = 2, K_LW = 3, K_SW = 4, K_ADDI = 5, K_ANDI = 6;
  localparam int K_ORI = 7, K_J = 8, K_JAL = 9, K_BR = 10, K_HALT = 11;

  localparam logic [5:0] OPS [18] = '{6'h00, 6'h00, 6'h23, 6'h2b, 6'h08, 6'h0c, 6'h0d, 6'h02,
                                      6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h09, 6'h0a, 6'h3f,
                                      6'h01, 6'h2e};

  function automatic int cls_of(logic [5:0] op, logic [5:0] fn);
    if (op == 6'h00) return (fn == 6'h08) ? K_JS : K_R;
    if (op == 6'h23) return K_LW;
    if (op == 6'h2b) return K_SW;
    if (op == 6'h08) return K_ADDI;
    if (op == 6'h0c) return K_ANDI;
    if (op == 6'h0d) return K_ORI;
    if (op == 6'h02) return K_J;
    if (op == 6'h03) return K_JAL;
    if (op inside {[6'd4:6'd7], 6'd9, 6'd10}) return K_BR;
    if (op == 6'h2d) return K_HALT;
    return K_ILL;
  endfunction

  // Expected control vector for a given phase (0=F,1=D,2=E,3=M,4=W,5=H) of an instruction.
  function automatic logic [17:0] exp_ctl(int ph, logic [5:0] op, logic [5:0] fn, logic rdy);
    logic [1:0] rd, m2r, jmp;
    logic       as, mw, mr, rw, br, hl, pcw, irw;
    logic [3:0] alu;
    int k;
    k = cls_of(op, fn);
    {rd, m2r, jmp} = '0;
    {as, mw, mr, rw, br, hl, pcw, irw} = '0;
    alu = '0;
    case (ph)
      0: begin irw = 1'b1; pcw = 1'b1; end
      1: if (k == K_J) begin jmp = 2'd1; pcw = 1'b1; end
      2: begin
        as = k inside {K_LW, K_SW, K_ADDI, K_ANDI, K_ORI};
        br = (k == K_BR);
        if (k == K_R) alu = 4'd2;
        else if (k == K_ANDI) alu = 4'd1;
        else if (k == K_ORI) alu = 4'd3;
        else if (k == K_BR) alu = (op <= 6'd7) ? 4'(op) : 4'(op - 6'd1);
      end
      3: begin
        mr = k inside {K_LW, K_JS};
        mw = k inside {K_SW, K_JAL};
        if (k == K_JAL) begin jmp = 2'd1; pcw = rdy; end
      end
      4: begin
        rw = 1'b1;
        if (k == K_R) rd = 2'd1;
        if (k == K_LW) m2r = 2'd1;
        if (k == K_JAL) begin m2r = 2'd2; rd = 2'd2; end
        if (k == K_JS) begin m2r = 2'd3; jmp = 2'd2; pcw = 1'b1; end
      end
      5: hl = 1'b1;
      default: ;
    endcase
    return {rd, as, m2r, mw, mr, alu, rw, br, jmp, hl, pcw, irw};
  endfunction

  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  task automatic do_reset();
    Reset = 1'b1; Stall = 1'b0; mem_ready = 1'b0; opcode = '0; funct = '0;
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      opcode = 6'($urandom); funct = 6'($urandom); mem_ready = 1'b1; Stall = 1'b0;
      #1;
      n_checks++; if (ctl !== 18'h0) $display("FAIL reset_ctl: got %h want 0", ctl); else n_pass++;
      n_checks++; if (state !== 3'd0) $display("FAIL reset_state: got %0d want 0", state); else n_pass++;
      n_checks++;
      if ({retired, illegal, bus_error} !== 18'h0)
        $display("FAIL reset_status: got %h want 0", {retired, illegal, bus_error});
      else n_pass++;
      tick();
    end
    Reset = 1'b0; opcode = '0; funct = '0; mem_ready = 1'b0;
    #1;
    n_checks++; if (ctl !== 18'h3) $display("FAIL reset_fetch: got %h want 3", ctl); else n_pass++;
  endtask

  task automatic test_add();
    int exp_st [5] = '{0, 1, 2, 4, 0};
    do_reset();
    opcode = 6'h00; funct = 6'h20;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (state !== 3'(exp_st[i])) $display("FAIL add_state%0d: got %0d want %0d", i, state, exp_st[i]);
      else n_pass++;
      if (i == 2) begin
        n_checks++; if (ALUOp !== 4'b0010) $display("FAIL add_aluop: got %b want 0010", ALUOp); else n_pass++;
      end
      if (i == 3) begin
        n_checks++;
        if ({RegWrite, RegDst, MemtoReg} !== 5'b10100)
          $display("FAIL add_wb: got %b want 10100", {RegWrite, RegDst, MemtoReg});
        else n_pass++;
      end
      tick();
    end
    n_checks++; if (retired !== 16'd1) $display("FAIL add_retired: got %0d want 1", retired); else n_pass++;
  endtask

  task automatic test_lw_wait();
    do_reset();
    opcode = 6'h23; funct = 6'h00;
    tick(); tick(); tick();
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      n_checks++;
      if ({state, MemRead} !== 4'b0111) $display("FAIL lw_mem%0d: got %b want 0111", i, {state, MemRead});
      else n_pass++;
      tick();
    end
    mem_ready = 1'b0;
    #1;
    n_checks++;
    if ({state, RegWrite, MemtoReg} !== 6'b100101)
      $display("FAIL lw_wb: got %b want 100101", {state, RegWrite, MemtoReg});
    else n_pass++;
    tick();
    n_checks++;
    if ({state, bus_error, retired} !== {3'd0, 1'b0, 16'd1})
      $display("FAIL lw_done: got %h want %h", {state, bus_error, retired}, {3'd0, 1'b0, 16'd1});
    else n_pass++;
  endtask

  task automatic test_sw_timeout();
    // Stalled cycles do not count; ready on the last allowed cycle still completes.
    do_reset();
    opcode = 6'h2b;
    tick(); tick(); tick();
    for (int i = 0; i < 20; i++) begin
      Stall = (i >= 14 && i < 19);
      mem_ready = (i == 19);
      tick();
    end
    Stall = 1'b0; mem_ready = 1'b0;
    #1;
    n_checks++;
    if ({state, bus_error, retired} !== {3'd0, 1'b0, 16'd1})
      $display("FAIL sw_edge: got %h want %h", {state, bus_error, retired}, {3'd0, 1'b0, 16'd1});
    else n_pass++;
    // Never ready: exactly MEM_TIMEOUT cycles in MEM, then HALT.
    do_reset();
    opcode = 6'h2b;
    tick(); tick(); tick();
    for (int i = 0; i < 15; i++) begin
      #1;
      n_checks++;
      if ({state, MemWrite} !== 4'b0111) $display("FAIL sw_mem%0d: got %b want 0111", i, {state, MemWrite});
      else n_pass++;
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      opcode = 6'($urandom); mem_ready = 1'($urandom);
      #1;
      n_checks++;
      if ({state, bus_error, ctl} !== {3'd5, 1'b1, 18'h4})
        $display("FAIL sw_halt%0d: got %h want %h", i, {state, bus_error, ctl}, {3'd5, 1'b1, 18'h4});
      else n_pass++;
      tick();
    end
    n_checks++; if (retired !== 16'd0) $display("FAIL sw_retired: got %0d want 0", retired); else n_pass++;
  endtask

  task automatic test_illegal_then_addi();
    do_reset();
    opcode = 6'h3f; funct = 6'h3f;
    tick();
    #1;
    n_checks++; if (ctl !== 18'h0) $display("FAIL ill_decode: got %h want 0", ctl); else n_pass++;
    tick();
    n_checks++;
    if ({state, illegal, retired} !== {3'd0, 1'b1, 16'd1})
      $display("FAIL ill_flag: got %h want %h", {state, illegal, retired}, {3'd0, 1'b1, 16'd1});
    else n_pass++;
    opcode = 6'h08; funct = 6'h00;
    tick(); tick();
    #1;
    n_checks++;
    if ({state, ALUSrc, ALUOp} !== {3'd2, 1'b1, 4'd0})
      $display("FAIL addi_exec: got %b want 010100000", {state, ALUSrc, ALUOp});
    else n_pass++;
    tick();
    #1;
    n_checks++;
    if ({RegWrite, RegDst} !== 3'b100) $display("FAIL addi_wb: got %b want 100", {RegWrite, RegDst});
    else n_pass++;
    tick();
    n_checks++;
    if ({state, illegal, retired} !== {3'd0, 1'b1, 16'd2})
      $display("FAIL addi_done: got %h want %h", {state, illegal, retired}, {3'd0, 1'b1, 16'd2});
    else n_pass++;
  endtask

  task automatic test_jal_js();
    do_reset();
    opcode = 6'h03; mem_ready = 1'b1;
    tick(); tick();
    opcode = 6'($urandom);
    #1;
    n_checks++;
    if ({state, MemWrite, Jump, PCWrite} !== 7'b0111011)
      $display("FAIL jal_mem: got %b want 0111011", {state, MemWrite, Jump, PCWrite});
    else n_pass++;
    tick();
    #1;
    n_checks++;
    if ({state, RegWrite, MemtoReg, RegDst} !== 8'b10011010)
      $display("FAIL jal_wb: got %b want 10011010", {state, RegWrite, MemtoReg, RegDst});
    else n_pass++;
    tick();
    opcode = 6'h00; funct = 6'h08; mem_ready = 1'b0;
    tick(); tick();
    #1;
    n_checks++;
    if ({state, MemRead} !== 4'b0111) $display("FAIL js_mem: got %b want 0111", {state, MemRead});
    else n_pass++;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    #1;
    n_checks++;
    if ({state, RegWrite, MemtoReg, Jump, PCWrite} !== 9'b100111101)
      $display("FAIL js_wb: got %b want 100111101", {state, RegWrite, MemtoReg, Jump, PCWrite});
    else n_pass++;
    tick();
    opcode = 6'h02;
    tick();
    #1;
    n_checks++;
    if ({state, Jump, PCWrite} !== 6'b001011) $display("FAIL j_decode: got %b want 001011", {state, Jump, PCWrite});
    else n_pass++;
    tick();
    n_checks++;
    if ({state, retired} !== {3'd0, 16'd3}) $display("FAIL j_done: got %h want %h", {state, retired}, {3'd0, 16'd3});
    else n_pass++;
  endtask

  task automatic test_stall_reset();
    do_reset();
    opcode = 6'h04;
    tick(); tick();
    Stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if ({state, Branch, retired, ctl} !== {3'd2, 1'b0, 16'd0, 18'h0})
        $display("FAIL stall%0d: got %h want %h", i, {state, Branch, retired, ctl}, {3'd2, 1'b0, 16'd0, 18'h0});
      else n_pass++;
      tick();
    end
    Stall = 1'b0;
    #1;
    n_checks++;
    if ({state, Branch, ALUOp} !== 8'b01010100) $display("FAIL beq_exec: got %b want 01010100", {state, Branch, ALUOp});
    else n_pass++;
    tick();
    n_checks++; if (retired !== 16'd1) $display("FAIL beq_retired: got %0d want 1", retired); else n_pass++;
    opcode = 6'h23;
    tick(); tick(); tick();
    n_checks++; if ({state, MemRead} !== 4'b0111) $display("FAIL lw_pre: got %b want 0111", {state, MemRead}); else n_pass++;
    Reset = 1'b1;
    #1;
    n_checks++;
    if ({state, ctl, retired, illegal, bus_error} !== 39'h0)
      $display("FAIL async_rst: got %h want 0", {state, ctl, retired, illegal, bus_error});
    else n_pass++;
    tick();
    Reset = 1'b0;
    #1;
    n_checks++; if ({state, ctl} !== {3'd0, 18'h3}) $display("FAIL post_rst: got %h want 3", {state, ctl}); else n_pass++;
    tick();
    n_checks++; if (state !== 3'd1) $display("FAIL post_rst_edge: got %0d want 1", state); else n_pass++;
  endtask

  task automatic test_random();
    int path[$];
    int k, delay, waited, ph;
    bit done, stl, rdy, exp_ill;
    logic [5:0] op, fn;
    logic [15:0] exp_ret;
    do_reset();
    exp_ret = '0; exp_ill = 1'b0;
    for (int n = 0; n < 80; n++) begin
      k = $urandom_range(0, 17);
      op = OPS[k];
      fn = 6'($urandom);
      if (k == 1) fn = 6'h08; else if (op == 6'h00 && fn == 6'h08) fn = 6'h20;
      k = cls_of(op, fn);
      case (k)
        K_R, K_ADDI, K_ANDI, K_ORI: path = {0, 1, 2, 4};
        K_LW:        path = {0, 1, 2, 3, 4};
        K_SW:        path = {0, 1, 2, 3};
        K_BR:        path = {0, 1, 2};
        K_JAL, K_JS: path = {0, 1, 3, 4};
        default:     path = {0, 1};
      endcase
      delay = $urandom_range(0, 4);
      waited = 0;
      foreach (path[i]) begin
        ph = path[i];
        done = 1'b0;
        while (!done) begin
          stl = ($urandom_range(0, 5) == 0);
          rdy = (ph == 3) ? (waited >= delay) : 1'($urandom);
          Stall = stl; mem_ready = rdy;
          opcode = (ph == 1) ? op : 6'($urandom);
          funct  = (ph == 1) ? fn : 6'($urandom);
          #1;
          n_checks++;
          if (state !== 3'(ph)) $display("FAIL rnd_state op=%h: got %0d want %0d", op, state, ph);
          else n_pass++;
          n_checks++;
          if (ctl !== (stl ? 18'h0 : exp_ctl(ph, op, fn, rdy)))
            $display("FAIL rnd_ctl op=%h ph=%0d: got %h want %h", op, ph, ctl,
                     stl ? 18'h0 : exp_ctl(ph, op, fn, rdy));
          else n_pass++;
          tick();
          if (!stl) begin
            if (ph == 3 && !rdy) waited++;
            else done = 1'b1;
          end
        end
      end
      exp_ret = exp_ret + 16'd1;
      if (k == K_ILL) exp_ill = 1'b1;
      Stall = 1'b0;
      #1;
      n_checks++;
      if ({retired, illegal, bus_error} !== {exp_ret, exp_ill, 1'b0})
        $display("FAIL rnd_status: got %h want %h", {retired, illegal, bus_error}, {exp_ret, exp_ill, 1'b0});
      else n_pass++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_sw_timeout();
    test_illegal_then_addi();
    test_jal_js();
    test_stall_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
